// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receive engine: pin synchronisers, clock glitch filter, 11-bit frame deserialiser
// and a one-entry valid/ready output register. Defining PS2_RX_TIMEOUT_EN adds an inter-edge timeout.
module ps2_rx_frame #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] dat_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       par_err_o,
    output logic       frm_err_o,
    output logic       ovf_o,
    output logic       busy_o
);

    // Filter counter only ever holds 0..FILT_LEN-1; the flip happens on the cycle it would reach FILT_LEN.
    localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic                   clk_s;
    logic                   dat_s;

    logic                   filt_level_reg;
    logic [CNT_W-1:0]       filt_cnt_reg;
    logic                   differ;
    logic                   flip;
    logic                   fall;

    state_t                 state_reg;
    logic [2:0]             bit_cnt_reg;
    logic [7:0]             shift_reg;
    logic                   parity_reg;
    logic                   busy_reg;
    logic [7:0]             dat_reg;
    logic                   valid_reg;
    logic                   par_err_reg;
    logic                   frm_err_reg;
    logic                   ovf_reg;
    logic                   deliver;
    logic                   accept;
    logic                   timeout;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_dat_i};
        end
    end

    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign dat_s = dat_sync_reg[SYNC_STAGES-1];

    assign differ = (clk_s != filt_level_reg);
    assign flip   = differ && (filt_cnt_reg == CNT_W'(FILT_LEN - 1));
    assign fall   = flip && filt_level_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_level_reg <= 1'b1;
            filt_cnt_reg   <= '0;
        end else if (!differ) begin
            filt_cnt_reg   <= '0;
        end else if (flip) begin
            filt_level_reg <= ~filt_level_reg;
            filt_cnt_reg   <= '0;
        end else begin
            filt_cnt_reg   <= filt_cnt_reg + 1'b1;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    logic [31:0] to_cnt_reg;

    // A fall pulse in the expiry cycle restarts the count instead of timing out.
    assign timeout = en_i && !fall && (state_reg != ST_IDLE) && (to_cnt_reg == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_reg <= '0;
        end else if (fall || (state_reg == ST_IDLE)) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 32'd1;
        end
    end
`else
    // No timeout hardware: a stalled frame waits indefinitely.
    assign timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    assign deliver = en_i && fall && (state_reg == ST_STOP) && dat_s && (^shift_reg ^ parity_reg);
    assign accept  = valid_reg && ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            dat_reg     <= 8'h00;
            valid_reg   <= 1'b0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            if (!en_i || timeout) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
                busy_reg    <= 1'b0;
                frm_err_reg <= timeout;
            end else if (fall) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= '0;
                            busy_reg    <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_reg   <= {dat_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) state_reg <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_reg <= dat_s;
                        state_reg  <= ST_STOP;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        if (!dat_s)                         frm_err_reg <= 1'b1;
                        else if (!(^shift_reg ^ parity_reg)) par_err_reg <= 1'b1;
                    end
                endcase
            end

            // One-entry output buffer: a byte arriving while full and not being drained is dropped.
            if (deliver) begin
                if (valid_reg && !ready_i) begin
                    ovf_reg <= 1'b1;
                end else begin
                    dat_reg   <= shift_reg;
                    valid_reg <= 1'b1;
                end
            end else if (accept) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign dat_o     = dat_reg;
    assign valid_o   = valid_reg;
    assign par_err_o = par_err_reg;
    assign frm_err_o = frm_err_reg;
    assign ovf_o     = ovf_reg;
    assign busy_o    = busy_reg;

endmodule
